// File: rtl/scroll_step_timer.sv
// Step timer for the 7-segment message scroller.
// A prescaler sets the step period, and each step event moves a wrapping step index up or down.
module scroll_step_timer #(
    parameter int TICK_DIV = 4194303,
    parameter int STEP_W   = 4,
    parameter int STEP_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              dir,
    input  logic              mode_oneshot,
    input  logic [1:0]        speed,
    input  logic              clear,
    output logic [STEP_W-1:0] step_count,
    output logic              tick,
    output logic              wrap,
    output logic              done
);

    localparam int PRE_W = $clog2(TICK_DIV + 1);
    localparam logic [PRE_W-1:0]  DIV = PRE_W'(TICK_DIV);
    localparam logic [STEP_W-1:0] MAX = STEP_W'(STEP_MAX);

    logic [PRE_W-1:0]  prescaler, prescaler_nxt, period_m1;
    logic [STEP_W-1:0] step_nxt;
    logic              tick_nxt, wrap_nxt, done_nxt;

    assign period_m1 = (DIV >> speed) - PRE_W'(1);

    // The >= compare means a shorter period set mid-count fires on the next edge instead of overrunning.
    always_comb begin
        prescaler_nxt = prescaler;
        step_nxt      = step_count;
        tick_nxt      = 1'b0;
        wrap_nxt      = 1'b0;
        done_nxt      = done;
        if (enable && !done) begin
            if (prescaler >= period_m1) begin
                prescaler_nxt = '0;
                tick_nxt      = 1'b1;
                if (!dir) begin
                    if (step_count < MAX) begin
                        step_nxt = step_count + STEP_W'(1);
                    end else if (!mode_oneshot) begin
                        step_nxt = '0;
                        wrap_nxt = 1'b1;
                    end
                    if (mode_oneshot && step_nxt == MAX) begin
                        done_nxt = 1'b1;
                    end
                end else begin
                    if (step_count != '0) begin
                        step_nxt = step_count - STEP_W'(1);
                    end else if (!mode_oneshot) begin
                        step_nxt = MAX;
                        wrap_nxt = 1'b1;
                    end
                    if (mode_oneshot && step_nxt == '0) begin
                        done_nxt = 1'b1;
                    end
                end
            end else begin
                prescaler_nxt = prescaler + PRE_W'(1);
            end
        end
        if (clear) begin
            prescaler_nxt = '0;
            step_nxt      = '0;
            tick_nxt      = 1'b0;
            wrap_nxt      = 1'b0;
            done_nxt      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler  <= '0;
            step_count <= '0;
            tick       <= 1'b0;
            wrap       <= 1'b0;
            done       <= 1'b0;
        end else begin
            prescaler  <= prescaler_nxt;
            step_count <= step_nxt;
            tick       <= tick_nxt;
            wrap       <= wrap_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_scroll_step_timer.sv
// Randomized and directed bench for scroll_step_timer.
// Every output is compared against an arithmetic model of the step timer.
module tb_scroll_step_timer;

    localparam int TICK_DIV = 8;
    localparam int STEP_W   = 2;
    localparam int STEP_MAX = 3;

    logic              clk = 1'b0;
    logic              reset, enable, dir, mode_oneshot, clear;
    logic [1:0]        speed;
    logic [STEP_W-1:0] step_count;
    logic              tick, wrap, done;

    int compared   = 0;
    int mismatched = 0;

    int elapsed, mStep, mTick, mWrap, mDone;

    scroll_step_timer #(
        .TICK_DIV(TICK_DIV), .STEP_W(STEP_W), .STEP_MAX(STEP_MAX)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir),
        .mode_oneshot(mode_oneshot), .speed(speed), .clear(clear),
        .step_count(step_count), .tick(tick), .wrap(wrap), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        elapsed = 0;
        mStep   = 0;
        mTick   = 0;
        mWrap   = 0;
        mDone   = 0;
    endtask

    // One clock edge of the behaviour, using the inputs currently driven.
    task automatic modelEdge();
        int period;
        mTick = 0;
        mWrap = 0;
        if (clear) begin
            modelReset();
        end else if (enable && mDone == 0) begin
            period = TICK_DIV >> speed;
            if (elapsed + 1 >= period) begin
                elapsed = 0;
                mTick   = 1;
                if (dir == 1'b0) begin
                    if (!(mode_oneshot && mStep == STEP_MAX)) begin
                        if (mStep == STEP_MAX) mWrap = 1;
                        mStep = (mStep + 1) % (STEP_MAX + 1);
                    end
                    if (mode_oneshot && mStep == STEP_MAX) mDone = 1;
                end else begin
                    if (!(mode_oneshot && mStep == 0)) begin
                        if (mStep == 0) mWrap = 1;
                        mStep = (mStep + STEP_MAX) % (STEP_MAX + 1);
                    end
                    if (mode_oneshot && mStep == 0) mDone = 1;
                end
            end else begin
                elapsed++;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".step"}, 32'(step_count), mStep);
        checkOutput({tag, ".tick"}, 32'(tick), mTick);
        checkOutput({tag, ".wrap"}, 32'(wrap), mWrap);
        checkOutput({tag, ".done"}, 32'(done), mDone);
    endtask

    // Called at a negedge: drives the inputs, crosses one posedge and checks at the following negedge.
    task automatic applyStimulus(input logic en, input logic d, input logic os,
                                 input logic [1:0] sp, input logic clr);
        enable       = en;
        dir          = d;
        mode_oneshot = os;
        speed        = sp;
        clear        = clr;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll("cycle");
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0; dir = 1'b0; mode_oneshot = 1'b0; speed = 2'd0; clear = 1'b0;
        modelReset();
        #1;
        checkAll("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0; dir = 1'b0; mode_oneshot = 1'b0; speed = 2'd0; clear = 1'b0;
        modelReset();

        doReset();
        for (int i = 1; i <= 32; i++) begin
            applyStimulus(1, 0, 0, 2'd0, 0);
            if (i == 8)  checkOutput("edge8_step", 32'(step_count), 1);
            if (i == 8)  checkOutput("edge8_tick", 32'(tick), 1);
            if (i == 24) checkOutput("edge24_step", 32'(step_count), 3);
            if (i == 31) checkOutput("edge31_tick", 32'(tick), 0);
        end
        checkOutput("edge32_wrap", 32'(wrap), 1);
        checkOutput("edge32_step", 32'(step_count), 0);

        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 2'd2, 0);
        checkOutput("speed2_tick", 32'(tick), 1);
        doReset();
        repeat (5) applyStimulus(1, 0, 0, 2'd0, 0);
        applyStimulus(1, 0, 0, 2'd3, 0);
        checkOutput("speed3_first", 32'(tick), 1);
        applyStimulus(1, 0, 0, 2'd3, 0);
        checkOutput("speed3_next", 32'(tick), 1);

        doReset();
        repeat (8) applyStimulus(1, 1, 0, 2'd0, 0);
        checkOutput("down_step", 32'(step_count), 3);
        checkOutput("down_wrap", 32'(wrap), 1);
        repeat (8) applyStimulus(1, 1, 0, 2'd0, 0);
        checkOutput("down_step2", 32'(step_count), 2);

        doReset();
        repeat (24) applyStimulus(1, 0, 1, 2'd0, 0);
        checkOutput("oneshot_step", 32'(step_count), 3);
        checkOutput("oneshot_done", 32'(done), 1);
        repeat (50) applyStimulus(1, 0, 1, 2'd0, 0);
        applyStimulus(1, 0, 1, 2'd0, 1);
        checkOutput("clear_done", 32'(done), 0);
        checkOutput("clear_step", 32'(step_count), 0);
        repeat (8) applyStimulus(1, 0, 1, 2'd0, 0);
        checkOutput("resume_step", 32'(step_count), 1);

        doReset();
        repeat (5) applyStimulus(1, 0, 0, 2'd0, 0);
        repeat (10) applyStimulus(0, 0, 0, 2'd0, 0);
        checkOutput("pause_step", 32'(step_count), 0);
        applyStimulus(1, 0, 0, 2'd0, 0);
        applyStimulus(1, 0, 0, 2'd0, 0);
        checkOutput("resume_tick2", 32'(tick), 0);
        applyStimulus(1, 0, 0, 2'd0, 0);
        checkOutput("resume_tick3", 32'(tick), 1);

        doReset();
        repeat (16) applyStimulus(1, 0, 0, 2'd0, 0);
        checkOutput("pre_async_step", 32'(step_count), 2);
        #2 reset = 1'b0;
        #1;
        modelReset();
        checkOutput("async_step", 32'(step_count), 0);
        checkOutput("async_tick", 32'(tick), 0);
        checkOutput("async_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b1;

        doReset();
        repeat (7) applyStimulus(1, 0, 0, 2'd0, 0);
        applyStimulus(1, 0, 0, 2'd0, 1);
        checkOutput("clear_event_tick", 32'(tick), 0);
        checkOutput("clear_event_step", 32'(step_count), 0);

        doReset();
        begin
            logic       rDir = 1'b0;
            logic       rOs  = 1'b0;
            logic [1:0] rSp  = 2'd0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 19) == 0) rSp = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0)  rDir = ~rDir;
                if ($urandom_range(0, 39) == 0) rOs = ~rOs;
                applyStimulus($urandom_range(0, 9) != 0, rDir, rOs, rSp,
                              $urandom_range(0, 59) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
